// File: rtl/cp0_intc_if.sv
// Pipeline-facing bundle of the cp0_intc coprocessor 0 block.
// The slave modport is the coprocessor side and the master modport is the pipeline side.
interface cp0_intc_if #(
    parameter int NUM_IRQ = 6
);
    logic [NUM_IRQ-1:0] irq_in;
    logic               exc_valid;
    logic [4:0]         exc_code;
    logic [31:0]        pc_ex;
    logic               pc_ex_valid;
    logic               eret;
    logic               write_c0;
    logic [4:0]         c0_waddr;
    logic [31:0]        c0_wdata;
    logic [4:0]         c0_raddr;
    logic [31:0]        c0_rdata;
    logic               take_exc;
    logic               take_eret;
    logic [31:0]        redirect_pc;
    logic               kernel_mode;

    modport slave (
        input  irq_in, exc_valid, exc_code, pc_ex, pc_ex_valid, eret,
        input  write_c0, c0_waddr, c0_wdata, c0_raddr,
        output c0_rdata, take_exc, take_eret, redirect_pc, kernel_mode
    );

    modport master (
        output irq_in, exc_valid, exc_code, pc_ex, pc_ex_valid, eret,
        output write_c0, c0_waddr, c0_wdata, c0_raddr,
        input  c0_rdata, take_exc, take_eret, redirect_pc, kernel_mode
    );
endinterface

// File: rtl/cp0_intc.sv
// Coprocessor 0 with Status/Cause/EPC, N maskable interrupts, exception priority and ERET.
// Define CP0_TIMER_EN to add the Count/Compare timer that drives Cause.TI.
module cp0_intc #(
    parameter int          NUM_IRQ     = 6,
    parameter logic [31:0] VECTOR_PC   = 32'h0000_0180,
    parameter int          SYNC_STAGES = 2
) (
    input logic       clk,
    input logic       reset,
    cp0_intc_if.slave bus
);
    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] CODE_RI      = 5'd10;

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
    logic                r_ie;
    logic                r_exl;
    logic [NUM_IRQ-1:0]  r_im;
    logic [4:0]          r_exc_code;
    logic [31:0]         r_epc;

    logic [NUM_IRQ-1:0]  w_ip;
    logic                w_ti;
    logic                w_timer_req;
    logic                w_eret_illegal;
    logic                w_sync_exc;
    logic                w_int_req;
    logic                w_take_exc;
    logic                w_take_eret;
    logic [4:0]          w_code;
    logic [31:0]         w_status;
    logic [31:0]         w_cause;
    logic [31:0]         w_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= bus.irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_ip = r_sync[SYNC_STAGES-1];

`ifdef CP0_TIMER_EN
    logic        r_im7;
    logic        r_ti;
    logic [31:0] r_count;
    logic [31:0] r_compare;

    // TI latches on a match and stays set until software rewrites Compare.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count   <= '0;
            r_compare <= 32'hFFFF_FFFF;
            r_ti      <= 1'b0;
        end else begin
            if (bus.write_c0 && bus.c0_waddr == ADDR_COUNT) begin
                r_count <= bus.c0_wdata;
            end else begin
                r_count <= r_count + 32'd1;
            end
            if (bus.write_c0 && bus.c0_waddr == ADDR_COMPARE) begin
                r_compare <= bus.c0_wdata;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign w_ti        = r_ti;
    assign w_timer_req = r_ti & r_im7;
`else
    assign w_ti        = 1'b0;
    assign w_timer_req = 1'b0;
`endif

    assign w_eret_illegal = bus.eret & ~r_exl;
    assign w_sync_exc     = bus.exc_valid | w_eret_illegal;
    assign w_int_req      = r_ie & ~r_exl & bus.pc_ex_valid & ((|(w_ip & r_im)) | w_timer_req);
    assign w_take_exc     = w_sync_exc | w_int_req;
    assign w_take_eret    = bus.eret & r_exl & ~w_take_exc;
    assign w_code         = bus.exc_valid ? bus.exc_code : (w_eret_illegal ? CODE_RI : 5'd0);

    // A flush in the same cycle squashes any mtc0 to Status or EPC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ie       <= 1'b0;
            r_exl      <= 1'b0;
            r_im       <= '0;
            r_exc_code <= '0;
            r_epc      <= '0;
`ifdef CP0_TIMER_EN
            r_im7      <= 1'b0;
`endif
        end else if (w_take_exc) begin
            r_exl      <= 1'b1;
            r_exc_code <= w_code;
            if (!r_exl) begin
                r_epc <= bus.pc_ex;
            end
        end else if (w_take_eret) begin
            r_exl <= 1'b0;
        end else if (bus.write_c0) begin
            if (bus.c0_waddr == ADDR_STATUS) begin
                r_ie  <= bus.c0_wdata[0];
                r_exl <= bus.c0_wdata[1];
                r_im  <= bus.c0_wdata[8 +: NUM_IRQ];
`ifdef CP0_TIMER_EN
                r_im7 <= bus.c0_wdata[15];
`endif
            end
            if (bus.c0_waddr == ADDR_EPC) begin
                r_epc <= bus.c0_wdata;
            end
        end
    end

    always_comb begin
        w_status              = '0;
        w_status[0]           = r_ie;
        w_status[1]           = r_exl;
        w_status[8 +: NUM_IRQ] = r_im;
`ifdef CP0_TIMER_EN
        w_status[15]          = r_im7;
`endif
    end

    always_comb begin
        w_cause               = '0;
        w_cause[6:2]          = r_exc_code;
        w_cause[8 +: NUM_IRQ] = w_ip;
        w_cause[15]           = w_ti;
    end

    always_comb begin
        w_rdata = '0;
        case (bus.c0_raddr)
            ADDR_STATUS:  w_rdata = w_status;
            ADDR_CAUSE:   w_rdata = w_cause;
            ADDR_EPC:     w_rdata = r_epc;
`ifdef CP0_TIMER_EN
            ADDR_COUNT:   w_rdata = r_count;
            ADDR_COMPARE: w_rdata = r_compare;
`endif
            default:      w_rdata = '0;
        endcase
    end

    assign bus.c0_rdata    = w_rdata;
    assign bus.take_exc    = w_take_exc;
    assign bus.take_eret   = w_take_eret;
    assign bus.redirect_pc = w_take_exc ? VECTOR_PC : (w_take_eret ? r_epc : 32'd0);
    assign bus.kernel_mode = r_exl;
endmodule

// File: tb/tb_cp0_intc.sv
// Self-checking bench for cp0_intc: directed scenarios followed by random traffic
// checked every cycle against a register-level reference model.
module tb_cp0_intc;
    localparam int          NIRQ = 6;
    localparam int          SS   = 2;
    localparam logic [31:0] VEC  = 32'h0000_0180;
`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cp0_intc_if #(.NUM_IRQ(NIRQ)) bus ();

    cp0_intc #(
        .NUM_IRQ    (NIRQ),
        .VECTOR_PC  (VEC),
        .SYNC_STAGES(SS)
    ) dut (
        .clk  (clk),
        .reset(reset_n),
        .bus  (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    bit            m_ie, m_exl, m_im7, m_ti;
    bit [NIRQ-1:0] m_im;
    bit [4:0]      m_code;
    bit [31:0]     m_epc, m_count, m_compare;
    bit [NIRQ-1:0] ipq[$];

    bit        e_exc, e_eret;
    bit [4:0]  e_code;
    bit [31:0] e_redirect;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_im7 = 0; m_ti = 0; m_im = '0;
        m_code = '0; m_epc = '0; m_count = '0;
        m_compare = TIMER ? 32'hFFFF_FFFF : 32'd0;
        ipq.delete();
        for (int i = 0; i < SS; i++) ipq.push_back('0);
    endtask

    function automatic bit [31:0] model_read(input bit [4:0] a);
        bit [31:0] r;
        r = 32'd0;
        case (a)
            5'd12: r = 32'(m_ie) | (32'(m_exl) << 1) | (32'(m_im) << 8) | (32'(m_im7 & TIMER) << 15);
            5'd13: r = (32'(m_code) << 2) | (32'(ipq[0]) << 8) | (32'(m_ti & TIMER) << 15);
            5'd14: r = m_epc;
            5'd9:  r = TIMER ? m_count : 32'd0;
            5'd11: r = TIMER ? m_compare : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic predict();
        bit src, ill, sync_exc, intr;
        src      = (|(ipq[0] & m_im)) || (TIMER && m_ti && m_im7);
        ill      = bus.eret && !m_exl;
        sync_exc = bus.exc_valid || ill;
        intr     = m_ie && !m_exl && bus.pc_ex_valid && src;
        e_exc    = sync_exc || intr;
        e_eret   = bus.eret && m_exl && !e_exc;
        e_code   = bus.exc_valid ? bus.exc_code : (ill ? 5'd10 : 5'd0);
        e_redirect = e_exc ? VEC : (e_eret ? m_epc : 32'd0);
    endtask

    task automatic model_edge();
        bit [31:0] old_count, old_cmp;
        old_count = m_count;
        old_cmp   = m_compare;
        if (e_exc) begin
            if (!m_exl) m_epc = bus.pc_ex;
            m_exl  = 1;
            m_code = e_code;
        end else if (e_eret) begin
            m_exl = 0;
        end else if (bus.write_c0) begin
            if (bus.c0_waddr == 5'd12) begin
                m_ie  = bus.c0_wdata[0];
                m_exl = bus.c0_wdata[1];
                m_im  = bus.c0_wdata[8 +: NIRQ];
                if (TIMER) m_im7 = bus.c0_wdata[15];
            end
            if (bus.c0_waddr == 5'd14) m_epc = bus.c0_wdata;
        end
        if (TIMER) begin
            m_count = (bus.write_c0 && bus.c0_waddr == 5'd9) ? bus.c0_wdata : m_count + 1;
            if (bus.write_c0 && bus.c0_waddr == 5'd11) begin
                m_compare = bus.c0_wdata;
                m_ti      = 0;
            end else if (old_count == old_cmp) begin
                m_ti = 1;
            end
        end
        ipq.push_back(bus.irq_in);
        void'(ipq.pop_front());
    endtask

    task automatic settle();
        #1;
        predict();
        check("take_exc", bus.take_exc, 32'(e_exc));
        check("take_eret", bus.take_eret, 32'(e_eret));
        check("redirect_pc", bus.redirect_pc, e_redirect);
        check("kernel_mode", bus.kernel_mode, 32'(m_exl));
        check("c0_rdata", bus.c0_rdata, model_read(bus.c0_raddr));
        $display("[TB] t=%0t raddr=%0d rdata=%08h take_exc=%0b take_eret=%0b redirect=%08h",
                 $time, bus.c0_raddr, bus.c0_rdata, bus.take_exc, bus.take_eret, bus.redirect_pc);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic clear();
        bus.exc_valid   = 0;
        bus.exc_code    = '0;
        bus.eret        = 0;
        bus.write_c0    = 0;
        bus.c0_waddr    = '0;
        bus.c0_wdata    = '0;
        bus.pc_ex_valid = 1;
        bus.pc_ex       = 32'($urandom_range(0, 1023)) << 2;
    endtask

    task automatic mtc0(input bit [4:0] a, input bit [31:0] d);
        clear();
        bus.write_c0 = 1;
        bus.c0_waddr = a;
        bus.c0_wdata = d;
        step();
    endtask

    initial begin
        bit found;
        bit [4:0] addr_list[6];
        addr_list = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};

        reset_n    = 0;
        bus.irq_in = '0;
        bus.c0_raddr = 5'd12;
        clear();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        // Reset state
        for (int i = 0; i < 6; i++) begin
            bus.c0_raddr = addr_list[i];
            settle();
        end
        check("rst_take_exc", bus.take_exc, 32'd0);
        check("rst_redirect", bus.redirect_pc, 32'd0);
        reset_n = 1;

        // Overflow exception
        clear();
        bus.exc_valid = 1; bus.exc_code = 5'd12; bus.pc_ex = 32'h40;
        bus.c0_raddr = 5'd14;
        settle();
        check("ov_take", bus.take_exc, 32'd1);
        check("ov_redirect", bus.redirect_pc, 32'h180);
        tick();
        clear();
        settle();
        check("ov_epc", bus.c0_rdata, 32'h40);
        check("ov_kernel", bus.kernel_mode, 32'd1);
        bus.c0_raddr = 5'd13;
        settle();
        check("ov_code", 32'(bus.c0_rdata[6:2]), 32'd12);

        // Legal ERET then illegal ERET
        mtc0(5'd14, 32'h44);
        clear();
        bus.eret = 1;
        settle();
        check("eret_take", bus.take_eret, 32'd1);
        check("eret_redirect", bus.redirect_pc, 32'h44);
        tick();
        clear();
        settle();
        check("eret_user", bus.kernel_mode, 32'd0);
        bus.eret = 1;
        settle();
        check("ri_take_exc", bus.take_exc, 32'd1);
        check("ri_no_eret", bus.take_eret, 32'd0);
        tick();
        clear();
        bus.c0_raddr = 5'd13;
        settle();
        check("ri_code", 32'(bus.c0_rdata[6:2]), 32'd10);
        tick();

        // Enabled interrupt: latency of SYNC_STAGES edges
        mtc0(5'd12, 32'h0000_0101);
        clear();
        bus.irq_in = 6'b000001;
        for (int i = 0; i < SS; i++) begin
            settle();
            check("irq_wait", bus.take_exc, 32'd0);
            tick();
        end
        settle();
        check("irq_take", bus.take_exc, 32'd1);
        tick();

        // Masked interrupt
        mtc0(5'd12, 32'h0000_0001);
        clear();
        bus.c0_raddr = 5'd13;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("masked_no_take", bus.take_exc, 32'd0);
            check("masked_ip0", 32'(bus.c0_rdata[8]), 32'd1);
            tick();
        end

        // Simultaneous exception, pending interrupt and mtc0 EPC
        mtc0(5'd12, 32'h0000_0101);
        clear();
        bus.exc_valid = 1; bus.exc_code = 5'd8; bus.pc_ex = 32'h200;
        bus.write_c0 = 1; bus.c0_waddr = 5'd14; bus.c0_wdata = 32'hDEAD_BEEC;
        settle();
        check("sim_take_exc", bus.take_exc, 32'd1);
        check("sim_no_eret", bus.take_eret, 32'd0);
        tick();
        clear();
        bus.c0_raddr = 5'd14;
        settle();
        check("sim_epc", bus.c0_rdata, 32'h200);
        bus.c0_raddr = 5'd13;
        settle();
        check("sim_code", 32'(bus.c0_rdata[6:2]), 32'd8);

        // Return, then bubbles with an irq pending
        bus.eret = 1;
        step();
        clear();
        bus.pc_ex_valid = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bubble_no_take", bus.take_exc, 32'd0);
            tick();
        end
        bus.pc_ex_valid = 1; bus.pc_ex = 32'h300;
        settle();
        check("bubble_then_take", bus.take_exc, 32'd1);
        tick();

        // Nested exception
        clear();
        bus.exc_valid = 1; bus.exc_code = 5'd12; bus.pc_ex = 32'h500;
        step();
        clear();
        bus.c0_raddr = 5'd14;
        settle();
        check("nest_epc", bus.c0_rdata, 32'h300);
        bus.c0_raddr = 5'd13;
        settle();
        check("nest_code", 32'(bus.c0_rdata[6:2]), 32'd12);

        // Asynchronous reset mid-handler
        #1 reset_n = 0;
        model_reset();
        bus.c0_raddr = 5'd12;
        #1 check("areset_status", bus.c0_rdata, 32'd0);
        check("areset_kernel", bus.kernel_mode, 32'd0);
        bus.c0_raddr = 5'd14;
        #1 check("areset_epc", bus.c0_rdata, 32'd0);
        bus.c0_raddr = 5'd13;
        #1 check("areset_cause", bus.c0_rdata, 32'd0);
        @(negedge clk);
        reset_n = 1;
        bus.irq_in = '0;

`ifdef CP0_TIMER_EN
        // Count/Compare timer interrupt
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd5);
        clear();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            settle();
            if (bus.take_exc) found = 1;
            tick();
        end
        check("timer_take", 32'(found), 32'd1);
        clear();
        bus.c0_raddr = 5'd13;
        settle();
        check("timer_ti_set", 32'(bus.c0_rdata[15]), 32'd1);
        mtc0(5'd11, 32'h0000_1000);
        clear();
        settle();
        check("timer_ti_clear", 32'(bus.c0_rdata[15]), 32'd0);
        tick();
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            clear();
            bus.irq_in      = NIRQ'($urandom);
            bus.exc_valid   = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 2))
                0: bus.exc_code = 5'd12;
                1: bus.exc_code = 5'd8;
                default: bus.exc_code = 5'd10;
            endcase
            bus.pc_ex_valid = ($urandom_range(0, 3) != 0);
            bus.eret        = ($urandom_range(0, 5) == 0);
            bus.write_c0    = ($urandom_range(0, 3) == 0);
            bus.c0_waddr    = addr_list[$urandom_range(0, 5)];
            bus.c0_wdata    = $urandom;
            if (bus.c0_waddr == 5'd12 && $urandom_range(0, 3) != 0) bus.c0_wdata[1] = 1'b0;
            bus.c0_raddr    = addr_list[$urandom_range(0, 5)];
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
